// File: rtl/multi_sel_pkg.sv
// Shared types and constants for the multi_sel multiplier and its downstream unpacker.
// Holds the product widths, the multiplier constants, the result-group layout and the framing phases.
package multi_sel_pkg;

    localparam int DW     = 11;
    localparam int OP_W   = 8;
    localparam int N_PROD = 4;

    localparam logic [DW-1:0] MUL_X1 = DW'(1);
    localparam logic [DW-1:0] MUL_X3 = DW'(3);
    localparam logic [DW-1:0] MUL_X7 = DW'(7);
    localparam logic [DW-1:0] MUL_X8 = DW'(8);
    localparam logic [DW-1:0] OP_MAX = DW'((1 << OP_W) - 1);

    typedef struct packed {
        logic [OP_W-1:0] d;
        logic [DW-1:0]   x3;
        logic [DW-1:0]   x7;
        logic [DW-1:0]   x8;
        logic            bad;
    } grp_t;

    typedef enum logic [$clog2(N_PROD)-1:0] {IDLE, P1, P2, P3} phase_t;

    // True when the four serial products are not d*1, d*3, d*7, d*8 of one 8-bit operand.
    function automatic logic grp_bad(input logic [DW-1:0] x1, input logic [DW-1:0] x3,
                                     input logic [DW-1:0] x7, input logic [DW-1:0] x8);
        return (x1 > OP_MAX) || (x1 * MUL_X1 != x1) || (x3 != x1 * MUL_X3) ||
               (x7 != x1 * MUL_X7) || (x8 != x1 * MUL_X8);
    endfunction

endpackage

// File: rtl/multi_sel_unpack_if.sv
// Bundle between the multi_sel serial stream, the unpacker and the next-stage consumer.
// master drives the serial stream and out_ready; slave is the unpacker side.
interface multi_sel_unpack_if #(
    parameter int DW    = 11,
    parameter int CNT_W = 8
);
    logic             input_grant;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_d;
    logic [DW-1:0]    out_x3;
    logic [DW-1:0]    out_x7;
    logic [DW-1:0]    out_x8;
    logic             out_bad;
    logic             sync_err;
    logic             ovf;
    logic [CNT_W-1:0] grp_cnt;

    modport master (
        output input_grant, in_data, out_ready,
        input  out_valid, out_d, out_x3, out_x7, out_x8, out_bad, sync_err, ovf, grp_cnt
    );

    modport slave (
        input  input_grant, in_data, out_ready,
        output out_valid, out_d, out_x3, out_x7, out_x8, out_bad, sync_err, ovf, grp_cnt
    );
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, head entry presented combinationally on rdat.
// Latency: 1 cycle push to visible head. Backpressure: push while full is refused unless a pop
// happens in the same cycle; the caller decides what a refused push means.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdat,
    input  logic         pop,
    output logic [W-1:0] rdat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdat    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdat;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (do_pop) rptr <= rptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/multi_sel_unpack.sv
// Re-frames the multi_sel d*1/d*3/d*7/d*8 serial stream into parallel checked result groups.
// Latency: 1 cycle from the d*8 cycle to out_valid on an empty buffer.
// Backpressure: groups queue in a DEPTH-entry FIFO; a completed group arriving to a full FIFO is dropped and flagged.
module multi_sel_unpack
    import multi_sel_pkg::*;
#(
    parameter int DW    = multi_sel_pkg::DW,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    multi_sel_unpack_if.slave bus
);
    phase_t           phase;
    logic [DW-1:0]    x1_q;
    logic [DW-1:0]    x3_q;
    logic [DW-1:0]    x7_q;
    logic             sync_err_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    grp_t wgrp;
    grp_t head;
    logic push;
    logic pop;
    logic push_ok;
    logic full;
    logic empty;

    // A grant in P3 restarts framing, so the partial group is never pushed.
    assign push    = (phase == P3) && !bus.input_grant;
    assign pop     = !empty && bus.out_ready;
    assign push_ok = push && (!full || pop);

    always_comb begin
        wgrp     = '0;
        wgrp.d   = x1_q[OP_W-1:0];
        wgrp.x3  = x3_q;
        wgrp.x7  = x7_q;
        wgrp.x8  = bus.in_data;
        wgrp.bad = grp_bad(x1_q, x3_q, x7_q, bus.in_data);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase      <= IDLE;
            x1_q       <= '0;
            x3_q       <= '0;
            x7_q       <= '0;
            sync_err_q <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (bus.input_grant) begin
                x1_q  <= bus.in_data;
                phase <= P1;
                if (phase != IDLE) sync_err_q <= 1'b1;
            end else begin
                case (phase)
                    P1: begin
                        x3_q  <= bus.in_data;
                        phase <= P2;
                    end
                    P2: begin
                        x7_q  <= bus.in_data;
                        phase <= P3;
                    end
                    default: phase <= IDLE;
                endcase
            end
            if (push && !push_ok) ovf_q <= 1'b1;
            if (push_ok && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    sync_fifo #(
        .W     ($bits(grp_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdat  (wgrp),
        .pop   (pop),
        .rdat  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_valid = !empty;
    assign bus.out_d     = head.d;
    assign bus.out_x3    = head.x3;
    assign bus.out_x7    = head.x7;
    assign bus.out_x8    = head.x8;
    assign bus.out_bad   = head.bad;
    assign bus.sync_err  = sync_err_q;
    assign bus.ovf       = ovf_q;
    assign bus.grp_cnt   = cnt_q;
endmodule

// File: tb/tb_multi_sel_unpack.sv
// Bench for multi_sel_unpack: directed test-plan steps then randomized streams against a
// queue-based reference model of framing, checking, buffering and the sticky flags.
module tb_multi_sel_unpack;
    localparam int DW    = 11;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    typedef struct {
        int d;
        int x3;
        int x7;
        int x8;
        int bad;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_sel_unpack_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    multi_sel_unpack #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t mq[$];
    int   part[$];
    int   sync_m = 0;
    int   ovf_m  = 0;
    int   cnt_m  = 0;
    int   rdy_mode = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", bus.out_valid, (mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_d",   bus.out_d,   mq[0].d);
            check("out_x3",  bus.out_x3,  mq[0].x3);
            check("out_x7",  bus.out_x7,  mq[0].x7);
            check("out_x8",  bus.out_x8,  mq[0].x8);
            check("out_bad", bus.out_bad, mq[0].bad);
        end
        check("sync_err", bus.sync_err, sync_m);
        check("ovf",      bus.ovf,      ovf_m);
        check("grp_cnt",  bus.grp_cnt,  cnt_m);
    endtask

    // Reference: a group is the grant value plus the next three values, if no grant intrudes.
    task automatic model_update(input bit g, input int data, input bit rdy);
        bit   pop;
        bit   done;
        exp_t gn;
        pop  = (mq.size() != 0) && rdy;
        done = 0;
        if (g) begin
            if (part.size() != 0) sync_m = 1;
            part.delete();
            part.push_back(data);
        end else if (part.size() != 0) begin
            part.push_back(data);
            if (part.size() == 4) begin
                gn.d   = part[0] % 256;
                gn.x3  = part[1];
                gn.x7  = part[2];
                gn.x8  = part[3];
                gn.bad = (part[0] > 255) || (part[1] != (3 * part[0]) % 2048) ||
                         (part[2] != (7 * part[0]) % 2048) || (part[3] != (8 * part[0]) % 2048);
                done = 1;
                part.delete();
            end
        end
        if (pop) void'(mq.pop_front());
        if (done) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(gn);
                if (cnt_m < 255) cnt_m++;
            end else begin
                ovf_m = 1;
            end
        end
    endtask

    task automatic step(input bit g, input int data);
        bit rdy;
        rdy = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
        @(negedge clk);
        check_outputs();
        bus.input_grant = g;
        bus.in_data     = DW'(data);
        bus.out_ready   = rdy;
        model_update(g, data, rdy);
    endtask

    task automatic send_group(input int d);
        step(1, d);
        step(0, 3 * d);
        step(0, 7 * d);
        step(0, 8 * d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 2047));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.input_grant = 1'b0;
        bus.out_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mq.delete();
        part.delete();
        sync_m = 0;
        ovf_m  = 0;
        cnt_m  = 0;
        check("rst_valid", bus.out_valid, 0);
        check("rst_d",     bus.out_d,     0);
        check("rst_x3",    bus.out_x3,    0);
        check("rst_x7",    bus.out_x7,    0);
        check("rst_x8",    bus.out_x8,    0);
        check("rst_bad",   bus.out_bad,   0);
        check("rst_sync",  bus.sync_err,  0);
        check("rst_ovf",   bus.ovf,       0);
        check("rst_cnt",   bus.grp_cnt,   0);
        rst = 1'b1;
    endtask

    initial begin
        bus.input_grant = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;

        do_reset();

        // d=5 single group
        rdy_mode = 1;
        send_group(5);
        idle(3);

        // back-to-back 255 then 0
        send_group(255);
        send_group(0);
        idle(3);
        check("b2b_sync", bus.sync_err, 0);
        check("b2b_cnt",  bus.grp_cnt,  3);

        // corrupt group then good group
        step(1, 10); step(0, 30); step(0, 71); step(0, 80);
        send_group(6);
        idle(3);

        // grant while in P2
        step(1, 3); step(0, 9);
        send_group(4);
        idle(3);
        check("p2_sync", bus.sync_err, 1);

        // overflow with ready held low
        do_reset();
        rdy_mode = 0;
        send_group(1);
        send_group(2);
        send_group(3);
        idle(2);
        check("ovf_set", bus.ovf,     1);
        check("ovf_cnt", bus.grp_cnt, 2);
        rdy_mode = 1;
        idle(4);
        check("ovf_drain", bus.out_valid, 0);

        // reset mid-group (in P2), then d=7
        step(1, 9); step(0, 27);
        do_reset();
        send_group(7);
        idle(3);
        check("rst_mid_sync", bus.sync_err, 0);
        check("rst_mid_ovf",  bus.ovf,      0);

        // randomized streams with random ready
        do_reset();
        rdy_mode = 2;
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    step(1, $urandom_range(0, 2047));
                    for (int k = 0; k < 3; k++) step(0, $urandom_range(0, 2047));
                end
                1: begin
                    step(1, $urandom_range(0, 255));
                    for (int k = 0; k < $urandom_range(0, 2); k++) step(0, $urandom_range(0, 2047));
                end
                2: idle($urandom_range(1, 4));
                default: send_group($urandom_range(0, 255));
            endcase
        end
        idle(6);

        // counter saturation with back-to-back groups
        rdy_mode = 1;
        for (int it = 0; it < 270; it++) send_group($urandom_range(0, 255));
        idle(3);
        check("cnt_sat", bus.grp_cnt, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
